// File: rtl/tile_boot_eoc_ctrl.sv
// Boot and end-of-computation sequencer for a set of tiles: holds each tile in
// reset, releases it, enables fetch, then captures its exit code or a timeout.
module tile_boot_eoc_ctrl #(
  parameter int unsigned N_TILES         = 4,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter logic [31:0] BOOT_ADDR       = 32'h0000_0080,
  parameter logic [31:0] EOC_ADDR_BASE   = 32'h0000_01F0,
  parameter logic [31:0] EOC_STRIDE      = 32'h0000_0004,
  parameter int unsigned RST_HOLD_CYCLES = 8,
  parameter int unsigned TIMEOUT_W       = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic [N_TILES-1:0]         tile_mask_i,
  input  logic [TIMEOUT_W-1:0]       timeout_i,
  input  logic [N_TILES-1:0]         mon_w_valid_i,
  input  logic [N_TILES*ADDR_W-1:0]  mon_w_addr_i,
  input  logic [N_TILES*DATA_W-1:0]  mon_w_data_i,
  output logic [N_TILES-1:0]         tile_rst_no,
  output logic [N_TILES-1:0]         fetch_enable_o,
  output logic [N_TILES*32-1:0]      boot_addr_o,
  output logic [N_TILES*32-1:0]      mhartid_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [N_TILES*DATA_W-1:0]  exit_code_o,
  output logic [N_TILES*2-1:0]       status_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_RUN,
    S_DONE_OK,
    S_DONE_TO
  } tile_state_e;

  localparam int unsigned HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_HOLD_CYCLES - 1);

  tile_state_e          state_q [N_TILES];
  tile_state_e          state_d [N_TILES];
  logic [HOLD_W-1:0]    hold_q  [N_TILES];
  logic [HOLD_W-1:0]    hold_d  [N_TILES];
  logic [TIMEOUT_W-1:0] run_q   [N_TILES];
  logic [TIMEOUT_W-1:0] run_d   [N_TILES];
  logic [DATA_W-1:0]    exit_q  [N_TILES];
  logic [DATA_W-1:0]    exit_d  [N_TILES];
  logic [DATA_W-1:0]    mon_data[N_TILES];

  logic [N_TILES-1:0]   fe_q, eoc_hit, in_flight, finished, mask_q;
  logic [TIMEOUT_W-1:0] timeout_q;
  logic                 done_q, start_ok, all_done;

  for (genvar g = 0; g < N_TILES; g++) begin : g_tile
    localparam logic [ADDR_W-1:0] EOC_ADDR = ADDR_W'(EOC_ADDR_BASE + EOC_STRIDE * 32'(g));

    assign mon_data[g] = mon_w_data_i[g*DATA_W +: DATA_W];
    // Only an odd value written to this tile's own EOC word ends its run.
    assign eoc_hit[g]  = mon_w_valid_i[g]
                         && (mon_w_addr_i[g*ADDR_W +: ADDR_W] == EOC_ADDR)
                         && mon_data[g][0];

    assign in_flight[g] = (state_q[g] == S_HOLD) || (state_q[g] == S_RUN);
    assign finished[g]  = (state_q[g] == S_DONE_OK) || (state_q[g] == S_DONE_TO);

    assign tile_rst_no[g]    = (state_q[g] == S_RUN) || finished[g];
    assign fetch_enable_o[g] = fe_q[g] && (state_q[g] == S_RUN);
    assign boot_addr_o[g*32 +: 32] = BOOT_ADDR;
    assign mhartid_o[g*32 +: 32]   = 32'(g);
    assign exit_code_o[g*DATA_W +: DATA_W] = exit_q[g];

    always_comb begin
      case (state_q[g])
        S_RUN:     status_o[g*2 +: 2] = 2'b01;
        S_DONE_OK: status_o[g*2 +: 2] = 2'b10;
        S_DONE_TO: status_o[g*2 +: 2] = 2'b11;
        default:   status_o[g*2 +: 2] = 2'b00;
      endcase
    end
  end

  assign busy_o   = |in_flight;
  assign done_o   = done_q;
  assign start_ok = start_i && !busy_o;
  assign all_done = (mask_q != '0) && ((mask_q & ~finished) == '0);

  // NOTE: every variable gets its hold value before any branch, so no path
  // through this block can leave one unassigned and infer a latch.
  always_comb begin
    for (int i = 0; i < N_TILES; i++) begin
      state_d[i] = state_q[i];
      hold_d[i]  = hold_q[i];
      run_d[i]   = run_q[i];
      exit_d[i]  = exit_q[i];

      if (start_ok) begin
        state_d[i] = tile_mask_i[i] ? S_HOLD : S_IDLE;
        hold_d[i]  = HOLD_LOAD;
        run_d[i]   = '0;
        exit_d[i]  = '0;
      end else begin
        case (state_q[i])
          S_HOLD: begin
            if (hold_q[i] == '0) begin
              state_d[i] = S_RUN;
              run_d[i]   = '0;
            end else begin
              hold_d[i] = hold_q[i] - HOLD_W'(1);
            end
          end
          S_RUN: begin
            // The EOC check comes first so a write landing on the timeout cycle still counts.
            if (eoc_hit[i]) begin
              state_d[i] = S_DONE_OK;
              exit_d[i]  = mon_data[i] >> 1;
            end else if ((timeout_q != '0) && (run_q[i] == timeout_q - TIMEOUT_W'(1))) begin
              state_d[i] = S_DONE_TO;
              exit_d[i]  = '1;
            end else if (run_q[i] != '1) begin
              run_d[i] = run_q[i] + TIMEOUT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update
  // together from the values seen before the edge. The per-tile arrays are
  // plain flops rather than a RAM, so they take the async reset like the rest.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_TILES; i++) begin
        state_q[i] <= S_IDLE;
        hold_q[i]  <= '0;
        run_q[i]   <= '0;
        exit_q[i]  <= '0;
      end
      fe_q      <= '0;
      mask_q    <= '0;
      timeout_q <= '0;
      done_q    <= 1'b0;
    end else begin
      for (int i = 0; i < N_TILES; i++) begin
        state_q[i] <= state_d[i];
        hold_q[i]  <= hold_d[i];
        run_q[i]   <= run_d[i];
        exit_q[i]  <= exit_d[i];
        // Fetch follows reset release by one cycle.
        fe_q[i]    <= (state_q[i] == S_RUN);
      end
      if (start_ok) begin
        mask_q    <= tile_mask_i;
        timeout_q <= timeout_i;
        done_q    <= (tile_mask_i == '0);
      end else if (all_done) begin
        done_q <= 1'b1;
      end
    end
  end

endmodule
